// File: rtl/sha256_pkg.sv
// Shared types, widths and the SHA-256 small-sigma functions used by the
// message schedule block.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Word-load and schedule-output bundle between the upstream message source,
// the schedule block and the compression stage.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic              clear;
    logic              word_valid;
    logic [WORD_W-1:0] word_in;
    logic              word_ready;
    logic              round_en;
    logic [WORD_W-1:0] w_out;
    logic              w_valid;
    logic [5:0]        round_idx;
    logic              block_done;
    logic              busy;

    modport master (
        output clear, word_valid, word_in, round_en,
        input  word_ready, w_out, w_valid, round_idx, block_done, busy
    );

    modport slave (
        input  clear, word_valid, word_in, round_en,
        output word_ready, w_out, w_valid, round_idx, block_done, busy
    );

endinterface

// File: rtl/flex_counter.sv
// Clearable up-counter cycling 0..rollover_val-1; rollover_flag flags the
// terminal count so the caller can act on the increment that wraps.
module flex_counter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            count_enable,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            rollover_flag
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] count_r;

    assign rollover_flag = (count_r == (rollover_val - ONE));
    assign count_out     = count_r;

    // Count register: clear has priority over counting, wrap on terminal count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + ONE;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words of a block, then emits W0..W(ROUNDS-1)
// from a sliding 16-word window, one word per round_en.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_schedule_if.slave bus
);

    localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);
    localparam logic [4:0] LOAD_ROLL = 5'd16;

    state_t            state_r;
    logic [5:0]        t_r;
    logic              w_valid_r;
    logic              block_done_r;
    logic              busy_r;
    logic [WORD_W-1:0] window_r [BLOCK_WORDS];

    logic [4:0]        count_s;
    logic              roll_s;
    logic              word_ready_s;
    logic              accept_s;
    logic              load_we_s;
    logic              load_done_s;
    logic              advance_s;
    logic              cnt_clear_s;
    logic [WORD_W-1:0] w_new_s;

    // Handshake and control decode for the current cycle.
    always_comb begin
        word_ready_s = 1'b0;
        if (!bus.clear && ((state_r == IDLE) || (state_r == LOAD))) begin
            word_ready_s = 1'b1;
        end else begin
            word_ready_s = 1'b0;
        end
        accept_s    = bus.word_valid && word_ready_s;
        // Counter never reaches 16, but an out-of-range slot must never be written.
        load_we_s   = accept_s && !count_s[4];
        load_done_s = accept_s && (state_r == LOAD) && roll_s;
        advance_s   = !bus.clear && (state_r == RUN) && bus.round_en;
        cnt_clear_s = bus.clear || load_done_s;
    end

    flex_counter #(
        .SIZE(5)
    ) u_load_cnt (
        .clk          (clk),
        .n_rst        (~rst),
        .clear        (cnt_clear_s),
        .count_enable (accept_s),
        .rollover_val (LOAD_ROLL),
        .count_out    (count_s),
        .rollover_flag(roll_s)
    );

    assign w_new_s = sigma1(window_r[14]) + window_r[9] + sigma0(window_r[1]) + window_r[0];

    // Control FSM with its registered status outputs and the round index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            t_r          <= 6'd0;
            w_valid_r    <= 1'b0;
            block_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else if (bus.clear) begin
            state_r      <= IDLE;
            t_r          <= 6'd0;
            w_valid_r    <= 1'b0;
            block_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_done_s) begin
                        state_r   <= RUN;
                        t_r       <= 6'd0;
                        w_valid_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (advance_s) begin
                        if (t_r == LAST_T) begin
                            state_r      <= DONE;
                            t_r          <= 6'd0;
                            w_valid_r    <= 1'b0;
                            block_done_r <= 1'b1;
                        end else begin
                            t_r <= t_r + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    block_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    t_r          <= 6'd0;
                    w_valid_r    <= 1'b0;
                    block_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Schedule window: parallel load during LOAD, shift-and-expand during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                window_r[i] <= '0;
            end
        end else if (load_we_s) begin
            window_r[count_s[3:0]] <= bus.word_in;
        end else if (advance_s) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                window_r[i] <= window_r[i+1];
            end
            window_r[BLOCK_WORDS-1] <= w_new_s;
        end
    end

    assign bus.word_ready = word_ready_s;
    assign bus.w_out      = window_r[0];
    assign bus.w_valid    = w_valid_r;
    assign bus.round_idx  = t_r;
    assign bus.block_done = block_done_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: known "abc" vectors plus random
// blocks checked against a plain-arithmetic SHA-256 schedule model.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic clk;
    logic rst;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] w;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg   [16];
    logic [31:0] exp_w [ROUNDS];
    logic [31:0] obs_w [ROUNDS];
    vec_t        abc_tab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: textbook SHA-256 expansion over the whole W array.
    task automatic compute_ref();
        for (int t = 0; t < ROUNDS; t++) begin
            if (t < 16) begin
                exp_w[t] = msg[t];
            end else begin
                exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    task automatic random_msg();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        compute_ref();
    endtask

    // Feed msg[0..stop_after-1]; stray round_en pulses must have no effect.
    task automatic load_block(input bit gapped, input int stop_after);
        int  n   = 0;
        int  cyc = 0;
        bit  acc;
        while (n < stop_after && cyc < 500) begin
            bus.word_in    = msg[n];
            bus.word_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            bus.round_en   = 1'($urandom_range(0, 1));
            #1;
            acc = bus.word_valid && bus.word_ready;
            chk("load_w_valid", 32'(bus.w_valid), 32'd0);
            chk("load_round_idx", 32'(bus.round_idx), 32'd0);
            chk("load_block_done", 32'(bus.block_done), 32'd0);
            step();
            cyc++;
            if (acc) n++;
        end
        bus.word_valid = 1'b0;
        bus.round_en   = 1'b0;
        if (n < stop_after) begin
            chk("load_timeout", 32'(n), 32'(stop_after));
        end else if (stop_after == 16) begin
            chk("run_w_valid", 32'(bus.w_valid), 32'd1);
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_idx0", 32'(bus.round_idx), 32'd0);
            chk("run_w0", bus.w_out, msg[0]);
        end
    endtask

    // Consume the schedule; optional 5-cycle stall at stall_at, clear at clear_at.
    task automatic run_block(input int stall_at, input int clear_at, input bit rand_stall);
        int k     = 0;
        int stall = 0;
        int cyc   = 0;
        bit en;
        bus.word_valid = 1'b1;
        bus.word_in    = $urandom;
        while (k < ROUNDS && cyc < 2000) begin
            obs_w[k] = bus.w_out;
            chk("w_valid", 32'(bus.w_valid), 32'd1);
            chk("w_out", bus.w_out, exp_w[k]);
            chk("round_idx", 32'(bus.round_idx), 32'(k));
            chk("word_ready_run", 32'(bus.word_ready), 32'd0);
            chk("block_done_early", 32'(bus.block_done), 32'd0);
            if (k == clear_at) begin
                bus.clear    = 1'b1;
                bus.round_en = 1'b1;
                step();
                bus.clear      = 1'b0;
                bus.round_en   = 1'b0;
                bus.word_valid = 1'b0;
                chk("clr_w_valid", 32'(bus.w_valid), 32'd0);
                chk("clr_busy", 32'(bus.busy), 32'd0);
                chk("clr_round_idx", 32'(bus.round_idx), 32'd0);
                chk("clr_block_done", 32'(bus.block_done), 32'd0);
                step();
                chk("clr_block_done2", 32'(bus.block_done), 32'd0);
                chk("clr_word_ready", 32'(bus.word_ready), 32'd1);
                return;
            end
            en = 1'b1;
            if (k == stall_at && stall < 5) begin
                en = 1'b0;
                stall++;
            end else if (rand_stall) begin
                en = ($urandom_range(0, 3) != 0);
            end
            bus.round_en = en;
            step();
            cyc++;
            if (en) k++;
        end
        if (k < ROUNDS) begin
            chk("run_timeout", 32'(k), 32'(ROUNDS));
        end
        chk("done_pulse", 32'(bus.block_done), 32'd1);
        chk("done_w_valid", 32'(bus.w_valid), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_word_ready", 32'(bus.word_ready), 32'd0);
        bus.round_en   = 1'b0;
        bus.word_valid = 1'b0;
        step();
        chk("after_done_pulse", 32'(bus.block_done), 32'd0);
        chk("after_done_busy", 32'(bus.busy), 32'd0);
        chk("after_done_word_ready", 32'(bus.word_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        abc_tab[0] = '{0,  32'h61626380};
        abc_tab[1] = '{1,  32'h00000000};
        abc_tab[2] = '{14, 32'h00000000};
        abc_tab[3] = '{15, 32'h00000018};
        abc_tab[4] = '{16, 32'h61626380};
        abc_tab[5] = '{17, 32'h000F0000};

        rst            = 1'b1;
        bus.clear      = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = 32'h0;
        bus.round_en   = 1'b0;
        step();
        step();
        chk("rst_w_out", bus.w_out, 32'h0);
        chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
        chk("rst_block_done", 32'(bus.block_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_round_idx", 32'(bus.round_idx), 32'd0);
        chk("rst_word_ready", 32'(bus.word_ready), 32'd1);
        rst = 1'b0;
        step();

        // "abc" single-block message, round_en held high.
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        compute_ref();
        load_block(1'b0, 16);
        run_block(-1, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("abc_W%0d", abc_tab[i].t), obs_w[abc_tab[i].t], abc_tab[i].w);
        end

        // Stall for 5 cycles at t = 20.
        random_msg();
        load_block(1'b0, 16);
        run_block(20, -1, 1'b0);

        // Clear at t = 30 together with round_en.
        random_msg();
        load_block(1'b0, 16);
        run_block(-1, 30, 1'b0);

        // Gapped upstream and random round_en gaps after the abort.
        random_msg();
        load_block(1'b1, 16);
        run_block(-1, -1, 1'b1);

        // Asynchronous reset after the 9th word, then a full reload.
        random_msg();
        load_block(1'b0, 9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_w_out", bus.w_out, 32'h0);
        chk("arst_w_valid", 32'(bus.w_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_round_idx", 32'(bus.round_idx), 32'd0);
        chk("arst_block_done", 32'(bus.block_done), 32'd0);
        step();
        rst = 1'b0;
        step();
        load_block(1'b0, 16);
        run_block(-1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
